// File: rtl/jtopl_timer_bank.sv
// Timer bank for OPL-family cores: NT up-counters sharing a frame prescaler,
// with per-timer reload, sticky flags, overflow pulses and a combined IRQ.
module jtopl_timer_bank #(
   parameter int NT        = 2,
   parameter int W         = 8,
   parameter int MULT_LOG2 = 2
)(
   input  logic            clk,
   input  logic            rst,
   input  logic            cenop,
   input  logic            zero,
   input  logic [NT*W-1:0] value,
   input  logic [NT-1:0]   load,
   input  logic [NT-1:0]   flagen,
   input  logic            clr_flags,
   output logic [NT-1:0]   flags,
   output logic [NT-1:0]   overflow,
   output logic            irq_n,
   output logic [NT:0]     status
);

   localparam int PW  = (NT-1)*MULT_LOG2;
   localparam int PWX = PW > 0 ? PW : 1;

   logic [PWX-1:0]       pcnt;
   logic [NT-1:0]        tick;
   logic [NT-1:0]        load_d;
   logic [NT-1:0]        ovf_now;
   logic [NT-1:0][W-1:0] cnt;

   generate
      if (PW > 0) begin : g_pre
         always_ff @(posedge clk or posedge rst) begin
            if (rst)
               pcnt <= '0;
            else if (cenop && zero)
               pcnt <= pcnt + 1'b1;
         end
      end else begin : g_nopre
         assign pcnt = '0;
      end
   endgenerate

   // Timer k ticks when the low k*MULT_LOG2 prescaler bits are all ones
   for (genvar k = 0; k < NT; k++) begin : g_tick
      localparam int SH = k*MULT_LOG2;
      localparam logic [PWX-1:0] MSK = PWX'((64'd1 << SH) - 64'd1);
      assign tick[k]    = zero & ((pcnt & MSK) == MSK);
      assign ovf_now[k] = load[k] & load_d[k] & tick[k] & (&cnt[k]);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         load_d   <= '0;
         cnt      <= '0;
         overflow <= '0;
         flags    <= '0;
      end else if (cenop) begin
         load_d   <= load;
         overflow <= ovf_now;
         for (int k = 0; k < NT; k++) begin
            if (load[k] && !load_d[k])
               cnt[k] <= value[k*W +: W];
            else if (ovf_now[k])
               cnt[k] <= value[k*W +: W];
            else if (load[k] && tick[k])
               cnt[k] <= cnt[k] + 1'b1;

            if (!flagen[k])
               flags[k] <= 1'b0;
            else if (ovf_now[k])
               flags[k] <= 1'b1;
            else if (clr_flags)
               flags[k] <= 1'b0;
         end
      end
   end

   assign irq_n  = ~|flags;
   assign status = {~irq_n, flags};

endmodule

// File: tb/tb_jtopl_timer_bank.sv
// Directed bench for jtopl_timer_bank: default bank plus wide and
// no-prescaler variants, checked with immediate assertions.
module tb_jtopl_timer_bank;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  logic        clk = 1'b0;
  logic        rst, cenop, zero, clr_flags;
  logic [15:0] value;
  logic [1:0]  load, flagen;
  logic [1:0]  flags, overflow;
  logic        irq_n;
  logic [2:0]  status;

  logic        zero2;
  logic [39:0] value2;
  logic [3:0]  load2, flagen2, flags2, overflow2;
  logic        irq_n2;
  logic [4:0]  status2;

  logic [15:0] value3;
  logic [1:0]  load3, flagen3, flags3, overflow3;
  logic        irq_n3;
  logic [2:0]  status3;

  always #5 clk = ~clk;

  jtopl_timer_bank dut (
    .clk(clk), .rst(rst), .cenop(cenop), .zero(zero),
    .value(value), .load(load), .flagen(flagen),
    .clr_flags(clr_flags), .flags(flags), .overflow(overflow),
    .irq_n(irq_n), .status(status)
  );

  jtopl_timer_bank #(.NT(4), .W(10), .MULT_LOG2(2)) dut2 (
    .clk(clk), .rst(rst), .cenop(cenop), .zero(zero2),
    .value(value2), .load(load2), .flagen(flagen2),
    .clr_flags(clr_flags), .flags(flags2), .overflow(overflow2),
    .irq_n(irq_n2), .status(status2)
  );

  jtopl_timer_bank #(.NT(2), .W(8), .MULT_LOG2(0)) dut3 (
    .clk(clk), .rst(rst), .cenop(cenop), .zero(zero2),
    .value(value3), .load(load3), .flagen(flagen3),
    .clr_flags(clr_flags), .flags(flags3), .overflow(overflow3),
    .irq_n(irq_n3), .status(status3)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse();
    cyc();
    zero = 1'b1;
    cyc();
    zero = 1'b0;
  endtask

  task automatic pulse2();
    cyc();
    zero2 = 1'b1;
    cyc();
    zero2 = 1'b0;
  endtask

  initial begin
    rst = 1'b1; cenop = 1'b1; zero = 1'b0; clr_flags = 1'b0;
    value = '0; load = '0; flagen = '0;
    zero2 = 1'b0; value2 = '0; load2 = '0; flagen2 = '0;
    value3 = '0; load3 = '0; flagen3 = '0;
    #2;
    chk("rst_flags", flags, 2'b00);
    chk("rst_ovf", overflow, 2'b00);
    chk("rst_irq", irq_n, 1'b1);
    chk("rst_status", status, 3'b000);
    cyc();
    rst = 1'b0;

    value = 16'hFF_FE; load = 2'b01; flagen = 2'b11;
    pulse();
    chk("t1_p1_ovf", overflow, 2'b00);
    chk("t1_p1_cnt", dut.cnt[0], 8'hFF);
    pulse();
    chk("t1_p2_ovf", overflow, 2'b01);
    chk("t1_p2_flags", flags, 2'b01);
    chk("t1_p2_irq", irq_n, 1'b0);
    chk("t1_p2_status", status, 3'b101);
    cyc();
    chk("t1_ovf_drop", overflow, 2'b00);
    pulse();
    chk("t1_p3_ovf", overflow, 2'b00);
    pulse();
    chk("t1_p4_ovf", overflow, 2'b01);

    load = 2'b11;
    pulse();
    chk("t2_p5_ovf", overflow, 2'b00);
    pulse();
    chk("t2_p6_ovf", overflow, 2'b01);
    pulse();
    chk("t2_p7_ovf", overflow, 2'b00);
    pulse();
    chk("t2_p8_ovf", overflow, 2'b11);
    chk("t2_p8_status", status, 3'b111);

    clr_flags = 1'b1;
    pulse();
    chk("t3_p9_flags", flags, 2'b00);
    chk("t3_p9_irq", irq_n, 1'b1);
    pulse();
    chk("t3_p10_ovf", overflow, 2'b01);
    chk("t3_set_beats_clr", flags, 2'b01);
    cyc();
    chk("t3_clr_next", flags, 2'b00);
    chk("t3_clr_irq", irq_n, 1'b1);
    clr_flags = 1'b0;
    pulse();
    chk("t3_p11_ovf", overflow, 2'b00);
    pulse();
    chk("t3_p12_ovf", overflow, 2'b11);
    chk("t3_p12_flags", flags, 2'b11);

    flagen = 2'b00;
    cyc();
    chk("t4_mask_clr", flags, 2'b00);
    chk("t4_mask_irq", irq_n, 1'b1);
    pulse();
    pulse();
    chk("t4_p14_ovf", overflow[0], 1'b1);
    chk("t4_p14_flags", flags, 2'b00);
    chk("t4_p14_irq", irq_n, 1'b1);
    flagen = 2'b11;

    value[7:0] = 8'h7F; load = 2'b10;
    cyc();
    load = 2'b11;
    cyc();
    chk("t5_reload7f", dut.cnt[0], 8'h7F);
    pulse();
    chk("t5_cnt80", dut.cnt[0], 8'h80);
    load = 2'b10;
    for (int i = 0; i < 10; i++) begin
      pulse();
      chk("t5_hold_cnt", dut.cnt[0], 8'h80);
      chk("t5_hold_ovf", overflow[0], 1'b0);
    end
    value[7:0] = 8'h10;
    cyc();
    load = 2'b11; zero = 1'b1;
    cyc();
    zero = 1'b0;
    chk("t5_rearm_cnt", dut.cnt[0], 8'h10);
    chk("t5_rearm_ovf", overflow[0], 1'b0);
    value[7:0] = 8'hFF; load = 2'b10;
    cyc();
    load = 2'b11;
    cyc();
    chk("t5_cntff", dut.cnt[0], 8'hFF);
    load = 2'b10;
    cyc();
    value[7:0] = 8'h10; load = 2'b11; zero = 1'b1;
    cyc();
    zero = 1'b0;
    chk("t5_term_cnt", dut.cnt[0], 8'h10);
    chk("t5_term_ovf", overflow[0], 1'b0);

    cenop = 1'b0; zero = 1'b1;
    cyc();
    cyc();
    zero = 1'b0; cenop = 1'b1;
    chk("t5_cen_hold", dut.cnt[0], 8'h10);

    value[7:0] = 8'hFF; load = 2'b10;
    cyc();
    load = 2'b11;
    cyc();
    zero = 1'b1;
    cyc();
    zero = 1'b0;
    chk("t6_pre_ovf", overflow[0], 1'b1);
    chk("t6_pre_flag", flags[0], 1'b1);
    cenop = 1'b0; rst = 1'b1;
    #1;
    chk("t6_flags", flags, 2'b00);
    chk("t6_ovf", overflow, 2'b00);
    chk("t6_irq", irq_n, 1'b1);
    chk("t6_status", status, 3'b000);
    chk("t6_cnt", dut.cnt[0], 8'h00);
    value[7:0] = 8'h33; load = 2'b01;
    @(negedge clk);
    rst = 1'b0; cenop = 1'b1;
    cyc();
    chk("t6_post_reload", dut.cnt[0], 8'h33);
    load = 2'b00;

    value2 = {30'h0, 10'h3FE}; load2 = 4'b0001; flagen2 = 4'b0001;
    value3 = 16'hFF_00; load3 = 2'b10; flagen3 = 2'b10;
    for (int i = 0; i < 4; i++) begin
      pulse2();
      chk("w_ovf", overflow2, (i % 2 == 1) ? 4'b0001 : 4'b0000);
      chk("m0_ovf", overflow3, 2'b10);
    end
    chk("w_status", status2, 5'h11);
    chk("w_irq", irq_n2, 1'b0);
    chk("m0_status", status3, 3'b110);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
